// File: rtl/openhw_lsu_lite_pkg.sv
// Shared types and constants for the lite load/store unit: config record,
// controller states, Funct3 size codes and the access byte-mask helper.
package openhw_lsu_lite_pkg;

    typedef struct packed {
        int   XLEN;
        logic A_SUPPORTED;
    } cvw_t;

    localparam cvw_t LSU_DEFAULT_CFG = '{XLEN: 64, A_SUPPORTED: 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_WRITE = 2'b01;
    localparam logic [1:0] MEM_READ  = 2'b10;
    localparam logic [1:0] MEM_AMO   = 2'b11;

    // Byte enables of an access at offset 0, indexed by Funct3[1:0].
    function automatic logic [7:0] sizeMask(input logic [1:0] sizeCode);
        case (sizeCode)
            2'b00:   sizeMask = 8'h01;
            2'b01:   sizeMask = 8'h03;
            2'b10:   sizeMask = 8'h0F;
            default: sizeMask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/openhw_subword_read.sv
// Load lane extraction: shifts the addressed lane down to bit 0, then
// sign- or zero-extends it according to Funct3.
module openhw_subword_read
    import openhw_lsu_lite_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] i_readData,
    input  logic [2:0]      i_offset,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_loadData
);

    logic [XLEN-1:0] w_lane;

    assign w_lane = i_readData >> {i_offset, 3'b000};

    always_comb begin
        o_loadData = w_lane;
        case (i_funct3)
            F3_B:    o_loadData = XLEN'($signed(w_lane[7:0]));
            F3_H:    o_loadData = XLEN'($signed(w_lane[15:0]));
            F3_W:    o_loadData = XLEN'($signed(w_lane[31:0]));
            F3_BU:   o_loadData = XLEN'(w_lane[7:0]);
            F3_HU:   o_loadData = XLEN'(w_lane[15:0]);
            F3_WU:   o_loadData = XLEN'(w_lane[31:0]);
            F3_D:    o_loadData = w_lane;
            default: o_loadData = w_lane;
        endcase
    end

endmodule

// File: rtl/openhw_lsu_lite.sv
// Minimal load/store unit: one single-beat bus access per M-stage instruction,
// with alignment checks, LR/SC reservation and the stall handshake.
module openhw_lsu_lite
    import openhw_lsu_lite_pkg::*;
#(
    parameter cvw_t P = LSU_DEFAULT_CFG
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [P.XLEN-1:0]     IEUAdrE,
    input  logic                  StallM,
    input  logic                  FlushM,
    input  logic                  StallW,
    input  logic                  FlushW,
    input  logic [1:0]            MemRWM,
    input  logic [1:0]            AtomicM,
    input  logic [2:0]            Funct3M,
    input  logic [P.XLEN-1:0]     WriteDataM,
    input  logic                  BusReady,
    input  logic [P.XLEN-1:0]     BusReadData,
    output logic                  BusReq,
    output logic                  BusWrite,
    output logic [P.XLEN-1:0]     BusAdr,
    output logic [P.XLEN-1:0]     BusWriteData,
    output logic [P.XLEN/8-1:0]   BusByteMask,
    output logic [P.XLEN-1:0]     ReadDataW,
    output logic                  SquashSCW,
    output logic                  LSUStallM,
    output logic                  LoadMisalignedM,
    output logic                  StoreMisalignedM,
    output logic                  AmoUnsupportedM
);

    localparam int XLEN = P.XLEN;
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    lsu_state_t         r_state;
    logic [XLEN-1:0]    r_IEUAdrM;
    logic [XLEN-1:0]    r_holdData;
    logic [XLEN-1-OFFW:0] r_resAdr;
    logic               r_resValid;

    logic [2:0]         w_offset;
    logic [1:0]         w_atomic;
    logic               w_active;
    logic               w_misaligned;
    logic               w_amo;
    logic               w_isLR;
    logic               w_isSC;
    logic               w_lineMatch;
    logic               w_scFail;
    logic               w_reqM;
    logic               w_done;
    logic [7:0]         w_maskWide;
    logic [XLEN-1:0]    w_rawRead;
    logic [XLEN-1:0]    w_loadData;

    assign w_offset = 3'(r_IEUAdrM[OFFW-1:0]);
    assign w_active = (MemRWM != MEM_NONE);
    assign w_atomic = P.A_SUPPORTED ? AtomicM : 2'b00;

    // Doubleword and word-unsigned do not exist on RV32, so they count as misaligned there.
    always_comb begin
        w_misaligned = 1'b0;
        case (Funct3M[1:0])
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = w_offset[0];
            2'b10:   w_misaligned = (w_offset[1:0] != 2'b00) || ((XLEN == 32) && Funct3M[2]);
            default: w_misaligned = (XLEN == 32) || (w_offset != 3'b000);
        endcase
    end

    assign w_amo       = w_active && ((MemRWM == MEM_AMO) || w_atomic[0]);
    assign w_isLR      = (MemRWM == MEM_READ)  && w_atomic[1];
    assign w_isSC      = (MemRWM == MEM_WRITE) && w_atomic[1];
    assign w_lineMatch = (r_resAdr == r_IEUAdrM[XLEN-1:OFFW]);
    assign w_scFail    = w_isSC && !(r_resValid && w_lineMatch);
    assign w_reqM      = w_active && !FlushM && !w_misaligned && !w_amo && !w_scFail;

    assign LoadMisalignedM  = (MemRWM == MEM_READ)  && w_misaligned;
    assign StoreMisalignedM = (MemRWM == MEM_WRITE) && w_misaligned;
    assign AmoUnsupportedM  = w_amo;

    assign BusReq    = ((r_state == IDLE) && w_reqM) || (r_state == BUSY);
    assign BusWrite  = BusReq && MemRWM[0];
    assign LSUStallM = BusReq && !BusReady;
    assign w_done    = BusReq && BusReady;
    assign BusAdr    = w_active ? {r_IEUAdrM[XLEN-1:OFFW], {OFFW{1'b0}}} : '0;

    assign w_maskWide  = sizeMask(Funct3M[1:0]) << w_offset;
    assign BusByteMask = BusWrite ? w_maskWide[NB-1:0] : '0;

    always_comb begin
        BusWriteData = '0;
        if (w_active) begin
            case (Funct3M[1:0])
                2'b00:   BusWriteData = {NB{WriteDataM[7:0]}};
                2'b01:   BusWriteData = {(XLEN/16){WriteDataM[15:0]}};
                2'b10:   BusWriteData = {(XLEN/32){WriteDataM[31:0]}};
                default: BusWriteData = WriteDataM;
            endcase
        end
    end

    // A flushed transaction still runs to BusReady; only then does the unit go idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_reqM) begin
                        if (!BusReady)   r_state <= BUSY;
                        else if (StallM) r_state <= DONE;
                    end
                end
                BUSY: begin
                    if (BusReady) r_state <= (StallM && !FlushM) ? DONE : IDLE;
                end
                DONE: begin
                    if (!StallM || FlushM) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || FlushM)  r_IEUAdrM <= '0;
        else if (!StallM)     r_IEUAdrM <= IEUAdrE;
    end

    always_ff @(posedge clk) begin
        if (reset)       r_holdData <= '0;
        else if (w_done) r_holdData <= BusReadData;
    end

    // An SC drops the reservation only as it leaves M, so its own pass/fail stays stable while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_resValid <= 1'b0;
            r_resAdr   <= '0;
        end else if (w_done && w_isLR && !FlushM) begin
            r_resValid <= 1'b1;
            r_resAdr   <= r_IEUAdrM[XLEN-1:OFFW];
        end else if ((w_isSC && !FlushM && !StallM) ||
                     (w_done && (MemRWM == MEM_WRITE) && !w_isSC && w_lineMatch)) begin
            r_resValid <= 1'b0;
        end
    end

    assign w_rawRead = (r_state == DONE) ? r_holdData : BusReadData;

    openhw_subword_read #(
        .XLEN(XLEN)
    ) u_subwordRead (
        .i_readData(w_rawRead),
        .i_offset  (w_offset),
        .i_funct3  (Funct3M),
        .o_loadData(w_loadData)
    );

    always_ff @(posedge clk) begin
        if (reset || FlushW) begin
            ReadDataW <= '0;
            SquashSCW <= 1'b0;
        end else if (!StallW) begin
            ReadDataW <= w_loadData;
            SquashSCW <= w_scFail && !FlushM;
        end
    end

endmodule
